// File: rtl/tl_phase_scheduler.sv
//==============================================================================
// tl_phase_scheduler : round-robin timed phase scheduler for a 4-movement
//                      intersection (A straight/left, B straight/left).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tl_phase_scheduler #(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 8,
  parameter int YELLOW_TIME = 2,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [1:0] phase,
  output logic       yellow
);

  // Encoding puts the phase index in [2:1] and the yellow flag in [0].
  typedef enum logic [2:0] {
    AG  = 3'b000,
    AGY = 3'b001,
    AL  = 3'b010,
    ALY = 3'b011,
    BG  = 3'b100,
    BGY = 3'b101,
    BL  = 3'b110,
    BLY = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);

  localparam logic [1:0] GREEN = 2'b00;
  localparam logic [1:0] YELW  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RED   = 2'b11;

  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic [3:0]       pend, pend_nx;
  logic [3:0]       sensor, own_mask, green_mask, other;
  logic [1:0]       cur, grant;
  logic             in_yellow;

  always_comb begin
    sensor     = {Tbl, Tb, Tal, Ta};
    cur        = state[2:1];
    in_yellow  = state[0];
    own_mask   = 4'b0001 << cur;
    green_mask = in_yellow ? 4'b0000 : own_mask;
    pend_nx    = (pend | sensor) & ~green_mask;
    other      = pend & ~own_mask;

    // Nearest pending requester after the current phase; descending scan so
    // the smallest offset is the one that sticks.
    grant = cur + 2'd1;
    for (int k = 3; k >= 1; k--) begin
      if (pend[cur + 2'(k)]) grant = cur + 2'(k);
    end

    state_nx = state;
    if (in_yellow) begin
      if (timer == YEL_LAST) state_nx = state_t'({grant, 1'b0});
    end else if ((|other) && (timer >= MIN_LAST) &&
                 (!sensor[cur] || (timer >= MAX_LAST))) begin
      state_nx = state_t'({cur, 1'b1});
    end

    if (state_nx != state)                   timer_nx = '0;
    else if (!in_yellow && timer == MAX_LAST) timer_nx = timer;
    else                                      timer_nx = timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AG;
      timer <= '0;
      pend  <= 4'b0000;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    La     = RED;
    Lb     = RED;
    phase  = cur;
    yellow = in_yellow;
    case (state)
      AG:       La = GREEN;
      AL:       La = LEFT;
      AGY, ALY: La = YELW;
      BG:       Lb = GREEN;
      BL:       Lb = LEFT;
      BGY, BLY: Lb = YELW;
      default:  ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tl_phase_scheduler.sv
//==============================================================================
// tb_tl_phase_scheduler : directed + randomized bench with a behavioural model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_tl_phase_scheduler;

  localparam int MIN_GREEN   = 4;
  localparam int MAX_GREEN   = 8;
  localparam int YELLOW_TIME = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Ta = 1'b0, Tal = 1'b0, Tb = 1'b0, Tbl = 1'b0;
  logic [1:0] La, Lb, phase;
  logic       yellow;

  tl_phase_scheduler #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_TIME(YELLOW_TIME), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .La(La), .Lb(Lb), .phase(phase), .yellow(yellow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current movement, yellow flag, cycles spent in the
  // current light state (unbounded) and an array of pending requests.
  int m_cur;
  bit m_yel;
  int m_cnt;
  bit m_pend [4];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [1:0] light(input int base);
    if (m_cur / 2 != base / 2) return 2'b11;
    if (m_yel) return 2'b01;
    return (m_cur == base) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_yel = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit [3:0] s);
    bit leave;
    bit any_other;
    int target;
    if (r) begin
      model_reset();
      return;
    end
    any_other = 0;
    for (int i = 0; i < 4; i++) if (i != m_cur && m_pend[i]) any_other = 1;
    target = (m_cur + 1) % 4;
    for (int d = 3; d >= 1; d--) if (m_pend[(m_cur + d) % 4]) target = (m_cur + d) % 4;
    if (m_yel) leave = (m_cnt + 1 == YELLOW_TIME);
    else leave = any_other && (m_cnt >= MIN_GREEN - 1) &&
                 (!s[m_cur] || m_cnt >= MAX_GREEN - 1);
    for (int i = 0; i < 4; i++)
      m_pend[i] = (m_pend[i] | s[i]) & !(!m_yel && i == m_cur);
    if (leave) begin
      if (m_yel) begin m_cur = target; m_yel = 0; end
      else m_yel = 1;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: compare current outputs with the model, apply inputs, advance.
  task automatic cyc(input bit r, input bit [3:0] s);
    check("La", {6'd0, La}, {6'd0, light(0)});
    check("Lb", {6'd0, Lb}, {6'd0, light(2)});
    check("phase", {6'd0, phase}, 8'(m_cur));
    check("yellow", {7'd0, yellow}, {7'd0, m_yel});
    check("safety", {7'd0, (La != 2'b11) && (Lb != 2'b11)}, 8'd0);
    reset = r;
    {Tbl, Tb, Tal, Ta} = s;
    @(posedge clk);
    model_step(r, s);
    #1;
  endtask

  task automatic do_reset();
    repeat (3) cyc(1'b1, 4'b0000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    model_reset();

    // Idle: stays in A green.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check("idle_La", {6'd0, La}, 8'd0);
      cyc(1'b0, 4'b0000);
    end

    // Tb pulse: yellow 4-5, BG from 6 and held.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) check("tb_green3", {6'd0, La}, 8'd0);
      if (i == 4) check("tb_yel4", {7'd0, yellow}, 8'd1);
      if (i == 6) check("tb_bg6", {2'd0, Lb, La, phase}, {2'd0, 2'b00, 2'b11, 2'd2});
      if (i == 15) check("tb_hold", {6'd0, Lb}, 8'd0);
      cyc(1'b0, (i == 0) ? 4'b0100 : 4'b0000);
    end

    // Ta held extends A green to MAX_GREEN.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 7) check("ext_green7", {6'd0, La}, 8'd0);
      if (i == 8) check("ext_yel8", {7'd0, yellow}, 8'd1);
      if (i == 10) check("ext_bg10", {6'd0, Lb}, 8'd0);
      cyc(1'b0, (i == 0) ? 4'b0101 : 4'b0001);
    end

    // Both left turns: AL at 6, ALY 10-11, BL at 12, never phase 2.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 6) check("left_al6", {6'd0, La}, 8'd2);
      if (i == 10) check("left_aly10", {6'd0, La}, 8'd1);
      if (i == 12) check("left_bl12", {4'd0, Lb, phase}, {4'd0, 2'b10, 2'd3});
      check("left_no_bg", {7'd0, phase == 2'd2}, 8'd0);
      cyc(1'b0, (i == 0) ? 4'b1010 : 4'b0000);
    end

    // Reset during AGY aborts and clears the pending B request.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i == 5) check("rst_ag", {4'd0, La, Lb}, {4'd0, 2'b00, 2'b11});
      if (i == 17) check("rst_stay", {6'd0, phase}, 8'd0);
      cyc(i == 4, (i == 0) ? 4'b0100 : 4'b0000);
    end

    // Tb held through BG is not latched; return to A and stay.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i == 13) check("bg_ext13", {6'd0, Lb}, 8'd0);
      if (i == 16) check("back_ag16", {6'd0, La}, 8'd0);
      if (i == 31) check("ag_stay", {6'd0, La}, 8'd0);
      cyc(1'b0, {1'b0, (i == 0) || (i >= 6 && i <= 13), 1'b0, i == 7});
    end

    // Tb pulsed during BGY is latched and B returns after A.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 12) check("bgy_ag12", {6'd0, La}, 8'd0);
      if (i == 18) check("bgy_bg18", {6'd0, Lb}, 8'd0);
      cyc(1'b0, {1'b0, i == 0 || i == 10, 1'b0, i == 6});
    end

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] s;
      for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 99) < 12);
      cyc($urandom_range(0, 199) == 0, s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
